// File: rtl/neuron_step_ctrl_if.sv
// Signal bundle between the neuron step sequencer, the time-step scheduler
// and the neuron datapath (integrator plus membrane register).
interface neuron_step_ctrl_if #(
    parameter int W = 21
);
    // Handshake: step_req, step_ack, int_start, v_next_valid and spike are
    // single-cycle pulses with no backpressure; a pulse is consumed on the
    // rising clk edge where it is high, and a step_req that finds the
    // sequencer busy is dropped and recorded in the sticky overrun flag.
    logic                step_req;
    logic                step_ack;
    logic                busy;
    logic                int_start;
    logic                v_next_valid;
    logic signed [W-1:0] v_next;
    logic signed [W-1:0] v_q;
    logic signed [W-1:0] v_d;
    logic                v_set;
    logic                spike;
    logic                refrac;
    logic                overrun;
    logic [2:0]          dbg_state;
    logic [3:0]          dbg_sub_cnt;

    modport master (
        input  step_req, v_next_valid, v_next, v_q,
        output step_ack, busy, int_start, v_d, v_set, spike, refrac, overrun,
        output dbg_state, dbg_sub_cnt
    );

    modport slave (
        output step_req, v_next_valid, v_next, v_q,
        input  step_ack, busy, int_start, v_d, v_set, spike, refrac, overrun,
        input  dbg_state, dbg_sub_cnt
    );
endinterface

// File: rtl/neuron_step_ctrl.sv
// Per-time-step sequencer for one neuron's membrane potential: integrator
// launches, result steering, threshold/spike detection and refractory hold.
module neuron_step_ctrl #(
    parameter int                  W            = 21,
    parameter logic signed [W-1:0] V_TH         = 21'sd15360,
    parameter int                  SUBSTEPS     = 2,
    parameter int                  REFRAC_STEPS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    neuron_step_ctrl_if.master    bus_io
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        FIRE  = 3'd4,
        REFR  = 3'd5
    } state_e;

    localparam logic [3:0] SUB_LAST   = 4'(SUBSTEPS - 1);
    localparam logic [3:0] REFR_START = 4'(REFRAC_STEPS);

    state_e     state_q, state_d;
    logic [3:0] sub_cnt_q, sub_cnt_d;
    logic [3:0] refr_cnt_q, refr_cnt_d;
    logic       step_ack_q, step_ack_d;
    logic       int_start_q, int_start_d;
    logic       spike_q, spike_d;
    logic       overrun_q, overrun_d;
    logic       at_threshold;

    assign at_threshold = (bus_io.v_q >= V_TH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sub_cnt_q   <= 4'd0;
            refr_cnt_q  <= 4'd0;
            step_ack_q  <= 1'b0;
            int_start_q <= 1'b0;
            spike_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_cnt_q   <= sub_cnt_d;
            refr_cnt_q  <= refr_cnt_d;
            step_ack_q  <= step_ack_d;
            int_start_q <= int_start_d;
            spike_q     <= spike_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sub_cnt_d  = sub_cnt_q;
        refr_cnt_d = refr_cnt_q;
        overrun_d  = overrun_q | (bus_io.step_req && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (bus_io.step_req) begin
                    if (refr_cnt_q == 4'd0) begin
                        state_d   = CALC;
                        sub_cnt_d = 4'd0;
                    end else begin
                        state_d = REFR;
                    end
                end
            end
            CALC: state_d = WAIT;
            WAIT: begin
                if (bus_io.v_next_valid) begin
                    if (sub_cnt_q == SUB_LAST) begin
                        state_d = CHECK;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 4'd1;
                        state_d   = CALC;
                    end
                end
            end
            CHECK: state_d = at_threshold ? FIRE : IDLE;
            FIRE: begin
                refr_cnt_d = REFR_START;
                state_d    = IDLE;
            end
            // Entered only with refr_cnt_q > 0, so the decrement cannot wrap.
            REFR: begin
                refr_cnt_d = refr_cnt_q - 4'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pulses are registered from the next state so each lines up with
        // the state it belongs to; the no-fire ack lands on the return to IDLE.
        int_start_d = (state_d == CALC);
        spike_d     = (state_d == FIRE);
        step_ack_d  = ((state_q == CHECK) && (state_d == IDLE)) ||
                      (state_d == FIRE) || (state_d == REFR);
    end

    assign bus_io.v_d = ((state_q == WAIT) && bus_io.v_next_valid) ? bus_io.v_next
                                                                   : bus_io.v_q;
    // Reset doubles as a membrane clear: the register loads the reset
    // potential on every edge while rst is held.
    assign bus_io.v_set       = rst || (state_q == FIRE) || (state_q == REFR);
    assign bus_io.busy        = (state_q != IDLE);
    assign bus_io.step_ack    = step_ack_q;
    assign bus_io.int_start   = int_start_q;
    assign bus_io.spike       = spike_q;
    assign bus_io.overrun     = overrun_q;
    assign bus_io.refrac      = (refr_cnt_q != 4'd0);
    assign bus_io.dbg_state   = state_q;
    assign bus_io.dbg_sub_cnt = sub_cnt_q;

endmodule

// File: tb/tb_neuron_step_ctrl.sv
// Directed bench for neuron_step_ctrl with a behavioural membrane register
// and a fixed-latency integrator attached.
module tb_neuron_step_ctrl;

    localparam int W           = 21;
    localparam int V_RST       = -35840;
    localparam int STEP_WINDOW = 12;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    neuron_step_ctrl_if #(.W(W)) bus ();

    neuron_step_ctrl #(
        .W(W), .V_TH(21'sd15360), .SUBSTEPS(2), .REFRAC_STEPS(3)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Membrane register with a bench-side preload port.
    logic                load_en = 1'b0;
    logic signed [W-1:0] load_val = '0;

    always @(posedge clk) begin
        if (bus.v_set)     bus.v_q <= W'(V_RST);
        else if (load_en)  bus.v_q <= load_val;
        else               bus.v_q <= bus.v_d;
    end

    // Integrator: captures v_q on int_start and raises v_next_valid int_lat+1
    // edges later. Results come from res_q when loaded, otherwise v_q+512.
    logic signed [W-1:0] res_q[$];
    logic signed [W-1:0] int_val = '0;
    int                  int_cnt = 0;
    int                  int_lat = 1;

    always @(posedge clk) begin
        bus.v_next_valid <= 1'b0;
        if (bus.int_start) begin
            int_cnt <= int_lat;
            if (res_q.size() != 0) int_val <= res_q.pop_front();
            else                   int_val <= bus.v_q + 21'sd512;
        end else if (int_cnt != 0) begin
            int_cnt <= int_cnt - 1;
            if (int_cnt == 1) begin
                bus.v_next_valid <= 1'b1;
                bus.v_next       <= int_val;
            end
        end
    end

    task automatic preload(input int val);
        load_en  = 1'b1;
        load_val = W'(val);
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Issues one step_req and observes a fixed window; cycle 1 is the cycle
    // after the request edge. An optional second request is injected at extra_at.
    task automatic run_step(input int extra_at, output int ack_at, output int n_int,
                            output int n_spk, output int n_ack, output logic spk_ack,
                            output logic vset_ack, output logic signed [W-1:0] vq_ack);
        ack_at = -1; n_int = 0; n_spk = 0; n_ack = 0;
        spk_ack = 1'b0; vset_ack = 1'b0; vq_ack = '0;
        @(negedge clk);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        for (int c = 1; c <= STEP_WINDOW; c++) begin
            if (bus.int_start === 1'b1) n_int++;
            if (bus.spike === 1'b1) n_spk++;
            if (bus.step_ack === 1'b1) begin
                n_ack++;
                if (ack_at < 0) begin
                    ack_at = c; spk_ack = bus.spike; vset_ack = bus.v_set; vq_ack = bus.v_q;
                end
            end
            bus.step_req = (c == extra_at);
            @(negedge clk);
        end
        bus.step_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.step_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL reset_vq: got %0d expected %0d", bus.v_q, V_RST); end
        n_checks++; if (bus.v_set !== 1'b1) begin n_fail++; $display("FAIL reset_vset: got %b expected 1", bus.v_set); end
        n_checks++; if ({bus.step_ack, bus.int_start, bus.spike, bus.overrun, bus.busy, bus.refrac} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 000000",
                {bus.step_ack, bus.int_start, bus.spike, bus.overrun, bus.busy, bus.refrac}); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.v_set !== 1'b0) begin n_fail++; $display("FAIL release_vset: got %b expected 0", bus.v_set); end
        @(negedge clk);
        n_checks++; if (bus.dbg_state !== 3'd0) begin n_fail++; $display("FAIL release_state: got %0d expected 0", bus.dbg_state); end
        n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL release_vq: got %0d expected %0d", bus.v_q, V_RST); end
    endtask

    task automatic test_subthreshold(input int start_v);
        int a, ni, ns, na; logic sa, va; logic signed [W-1:0] vqa;
        run_step(0, a, ni, ns, na, sa, va, vqa);
        n_checks++; if (a !== 8) begin n_fail++; $display("FAIL sub_latency: got %0d expected 8", a); end
        n_checks++; if (ni !== 2) begin n_fail++; $display("FAIL sub_int_start: got %0d expected 2", ni); end
        n_checks++; if (ns !== 0) begin n_fail++; $display("FAIL sub_spike: got %0d expected 0", ns); end
        n_checks++; if (na !== 1) begin n_fail++; $display("FAIL sub_ack_count: got %0d expected 1", na); end
        n_checks++; if (bus.v_q !== 21'(start_v + 1024)) begin n_fail++; $display("FAIL sub_vq: got %0d expected %0d", bus.v_q, start_v + 1024); end
    endtask

    task automatic test_fire(input int pre, input int r0, input int r1);
        int a, ni, ns, na; logic sa, va; logic signed [W-1:0] vqa;
        preload(pre);
        res_q.push_back(W'(r0));
        res_q.push_back(W'(r1));
        run_step(0, a, ni, ns, na, sa, va, vqa);
        n_checks++; if (a !== 8) begin n_fail++; $display("FAIL fire_latency: got %0d expected 8", a); end
        n_checks++; if (sa !== 1'b1 || ns !== 1) begin n_fail++; $display("FAIL fire_spike_with_ack: got %b/%0d expected 1/1", sa, ns); end
        n_checks++; if (va !== 1'b1) begin n_fail++; $display("FAIL fire_vset: got %b expected 1", va); end
        n_checks++; if (vqa !== 21'(r1)) begin n_fail++; $display("FAIL fire_vq_at_ack: got %0d expected %0d", vqa, r1); end
        n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL fire_vq_after: got %0d expected %0d", bus.v_q, V_RST); end
        n_checks++; if (bus.refrac !== 1'b1) begin n_fail++; $display("FAIL fire_refrac: got %b expected 1", bus.refrac); end
    endtask

    task automatic test_refractory(input logic check_fourth);
        int a, ni, ns, na; logic sa, va; logic signed [W-1:0] vqa;
        for (int k = 0; k < 3; k++) begin
            run_step(0, a, ni, ns, na, sa, va, vqa);
            n_checks++; if (a !== 1 || na !== 1) begin n_fail++; $display("FAIL refr_ack[%0d]: got at %0d count %0d expected at 1 count 1", k, a, na); end
            n_checks++; if (ni !== 0 || va !== 1'b1) begin n_fail++; $display("FAIL refr_no_int[%0d]: got int %0d vset %b expected 0/1", k, ni, va); end
            n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL refr_vq[%0d]: got %0d expected %0d", k, bus.v_q, V_RST); end
            n_checks++; if (bus.refrac !== (k < 2)) begin n_fail++; $display("FAIL refr_flag[%0d]: got %b expected %b", k, bus.refrac, k < 2); end
        end
        if (check_fourth) test_subthreshold(V_RST);
    endtask

    task automatic test_most_negative();
        int a, ni, ns, na; logic sa, va; logic signed [W-1:0] vqa;
        res_q.push_back(W'(0));
        res_q.push_back(W'(-1048576));
        run_step(0, a, ni, ns, na, sa, va, vqa);
        n_checks++; if (a !== 8 || ns !== 0) begin n_fail++; $display("FAIL neg_no_fire: got ack %0d spikes %0d expected 8/0", a, ns); end
        n_checks++; if (bus.v_q !== 21'(-1048576)) begin n_fail++; $display("FAIL neg_vq: got %0d expected -1048576", bus.v_q); end
    endtask

    task automatic test_overrun();
        int a, ni, ns, na; logic sa, va; logic signed [W-1:0] vqa;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b expected 0", bus.overrun); end
        run_step(2, a, ni, ns, na, sa, va, vqa);
        n_checks++; if (na !== 1 || a !== 8) begin n_fail++; $display("FAIL overrun_acks: got count %0d at %0d expected 1 at 8", na, a); end
        n_checks++; if (ni !== 2) begin n_fail++; $display("FAIL overrun_int_start: got %0d expected 2", ni); end
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
        run_step(0, a, ni, ns, na, sa, va, vqa);
        n_checks++; if (bus.overrun !== 1'b1 || a !== 8) begin n_fail++; $display("FAIL overrun_sticky: got %b ack %0d expected 1 ack 8", bus.overrun, a); end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        int n_valid = 0;
        int_lat = 4;
        preload(1000);
        @(negedge clk);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
        n_checks++; if (bus.int_start !== 1'b1) begin n_fail++; $display("FAIL mid_int_start: got %b expected 1", bus.int_start); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.v_set !== 1'b1) begin n_fail++; $display("FAIL mid_async: got busy %b vset %b expected 0/1", bus.busy, bus.v_set); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun_clear: got %b expected 0", bus.overrun); end
        @(negedge clk);
        n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL mid_vq_reset: got %0d expected %0d", bus.v_q, V_RST); end
        rst = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            if (bus.step_ack !== 1'b0 || bus.spike !== 1'b0) bad++;
            if (bus.v_next_valid === 1'b1) n_valid++;
            @(negedge clk);
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_ack_spike: got %0d pulses expected 0", bad); end
        n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL mid_late_valid: got %0d expected 1", n_valid); end
        n_checks++; if (bus.v_q !== 21'(V_RST)) begin n_fail++; $display("FAIL mid_vq_hold: got %0d expected %0d", bus.v_q, V_RST); end
        int_lat = 1;
    endtask

    initial begin
        bus.step_req = 1'b0;
        test_reset();
        test_subthreshold(V_RST);
        test_fire(15000, 15360, 15500);
        test_refractory(1'b1);
        test_fire(0, 100, 15360);
        test_refractory(1'b0);
        test_most_negative();
        test_overrun();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
